platformniossdram_pio_ext: RTL and testbench

- Parametrised successor to the Avalon-MM output PIO in the Nios/SDRAM platform. Adds per-bit direction control, synchronised input sampling, edge capture and a level interrupt to the Nios.
- Sits on the Avalon-MM system interconnect as slave s1.
- Drives board I/O through `out_port`/`oe`; the tri-state buffer lives at top level.

---
 rtl/platformniossdram_pio_ext.sv | 111 +++++++++++
 tb/tb_platformniossdram_pio_ext.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/platformniossdram_pio_ext.sv
// Avalon-MM slave PIO with per-bit direction, synchronised inputs, sticky edge capture and level irq.
// Optional macro PIO_OUTSETCLR_EN enables atomic set/clear of data_out at addresses 4/5.
module platformniossdram_pio_ext #(
    parameter int          WIDTH       = 32,
    parameter logic [31:0] RESET_VALUE = 32'h0,
    parameter logic [31:0] DIR_RESET   = 32'h0,
    parameter int          EDGE_TYPE   = 0,
    parameter int          SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic [WIDTH-1:0] out_port,
    output logic [WIDTH-1:0] oe,
    output logic             irq
);

    localparam logic [2:0] ADDR_DATA    = 3'd0;
    localparam logic [2:0] ADDR_DIR     = 3'd1;
    localparam logic [2:0] ADDR_IRQMASK = 3'd2;
    localparam logic [2:0] ADDR_EDGECAP = 3'd3;
`ifdef PIO_OUTSETCLR_EN
    localparam logic [2:0] ADDR_OUTSET  = 3'd4;
    localparam logic [2:0] ADDR_OUTCLR  = 3'd5;
`endif

    logic [WIDTH-1:0] r_sync [SYNC_STAGES];
    logic [WIDTH-1:0] r_prev;
    logic [WIDTH-1:0] r_data_out;
    logic [WIDTH-1:0] r_dir;
    logic [WIDTH-1:0] r_irq_mask;
    logic [WIDTH-1:0] r_edge_cap;
    logic             r_irq;

    logic             w_wr;
    logic [WIDTH-1:0] w_wdata;
    logic [WIDTH-1:0] w_sync;
    logic [WIDTH-1:0] w_det;
    logic [WIDTH-1:0] w_clr;
    logic [WIDTH-1:0] w_rd;
    logic             w_unused_wdata;

    assign w_wr           = chipselect & ~write_n;
    assign w_wdata        = writedata[WIDTH-1:0];
    assign w_unused_wdata = ^writedata;
    assign w_sync         = r_sync[SYNC_STAGES-1];
    assign w_clr          = (w_wr && address == ADDR_EDGECAP) ? w_wdata : '0;

    always_comb begin
        w_det = '0;
        case (EDGE_TYPE)
            0:       w_det = w_sync & ~r_prev;
            1:       w_det = ~w_sync & r_prev;
            default: w_det = w_sync ^ r_prev;
        endcase
    end

    // prev is cleared with the chain so stale pre-reset levels never look like edges
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= '0;
            r_prev     <= '0;
            r_data_out <= RESET_VALUE[WIDTH-1:0];
            r_dir      <= DIR_RESET[WIDTH-1:0];
            r_irq_mask <= '0;
            r_edge_cap <= '0;
            r_irq      <= 1'b0;
        end else begin
            r_sync[0] <= in_port;
            for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
            r_prev     <= w_sync;
            r_edge_cap <= (r_edge_cap & ~w_clr) | w_det;
            r_irq      <= |(r_edge_cap & r_irq_mask);
            if (w_wr) begin
                case (address)
                    ADDR_DATA:    r_data_out <= w_wdata;
                    ADDR_DIR:     r_dir      <= w_wdata;
                    ADDR_IRQMASK: r_irq_mask <= w_wdata;
`ifdef PIO_OUTSETCLR_EN
                    ADDR_OUTSET:  r_data_out <= r_data_out | w_wdata;
                    ADDR_OUTCLR:  r_data_out <= r_data_out & ~w_wdata;
`endif
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        w_rd = '0;
        case (address)
            ADDR_DATA:    w_rd = (w_sync & ~r_dir) | (r_data_out & r_dir);
            ADDR_DIR:     w_rd = r_dir;
            ADDR_IRQMASK: w_rd = r_irq_mask;
            ADDR_EDGECAP: w_rd = r_edge_cap;
            default:      w_rd = '0;
        endcase
        readdata = '0;
        readdata[WIDTH-1:0] = w_rd;
    end

    assign out_port = r_data_out;
    assign oe       = r_dir;
    assign irq      = r_irq;

endmodule

// File: tb/tb_platformniossdram_pio_ext.sv
// Self-checking bench for platformniossdram_pio_ext (WIDTH=8, RESET_VALUE=A5, DIR_RESET=FF, rising edges).
module tb_platformniossdram_pio_ext;
    localparam int W  = 8;
    localparam int S  = 2;
    localparam int ET = 0;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic [2:0]   address = '0;
    logic         chipselect = 1'b0;
    logic         write_n = 1'b1;
    logic [31:0]  writedata = '0;
    logic [31:0]  readdata;
    logic [W-1:0] in_port = '0;
    logic [W-1:0] out_port;
    logic [W-1:0] oe;
    logic         irq;

    int n_vec = 0;
    int n_err = 0;
    logic [W-1:0] tb_in = '0;

    // model: sync is simply in_port delayed S clocks, prev is that delayed one more
    logic [W-1:0] m_hist [S+1];
    logic [W-1:0] m_data, m_dir, m_mask, m_ec;
    logic         m_irq;

    platformniossdram_pio_ext #(
        .WIDTH(W), .RESET_VALUE(32'hA5), .DIR_RESET(32'hFF),
        .EDGE_TYPE(ET), .SYNC_STAGES(S)
    ) dut (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(readdata),
        .in_port(in_port), .out_port(out_port), .oe(oe), .irq(irq)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL timeout: simulation time limit reached");
        $fatal(1, "timeout");
    end

    function automatic logic [31:0] m_read(input logic [2:0] a);
        logic [W-1:0] s;
        s = m_hist[S-1];
        case (a)
            3'd0:    return {24'h0, (s & ~m_dir) | (m_data & m_dir)};
            3'd1:    return {24'h0, m_dir};
            3'd2:    return {24'h0, m_mask};
            3'd3:    return {24'h0, m_ec};
            default: return 32'h0;
        endcase
    endfunction

    task automatic cycle(input bit rst_n, input bit cs, input bit wn, input logic [2:0] a,
                         input logic [31:0] wd, input logic [W-1:0] inp);
        logic [W-1:0] s, p, det, clr;
        logic         irq_n;
        reset_n = rst_n; chipselect = cs; write_n = wn; address = a; writedata = wd; in_port = inp;
        @(posedge clk);
        if (!rst_n) begin
            for (int i = 0; i <= S; i++) m_hist[i] = '0;
            m_data = 8'hA5; m_dir = 8'hFF; m_mask = '0; m_ec = '0; m_irq = 1'b0;
        end else begin
            s = m_hist[S-1];
            p = m_hist[S];
            if (ET == 0)      det = s & ~p;
            else if (ET == 1) det = ~s & p;
            else              det = s ^ p;
            irq_n = |(m_ec & m_mask);
            clr = (cs && !wn && a == 3'd3) ? wd[W-1:0] : '0;
            m_ec = (m_ec & ~clr) | det;
            if (cs && !wn) begin
                if (a == 3'd0) m_data = wd[W-1:0];
                if (a == 3'd1) m_dir  = wd[W-1:0];
                if (a == 3'd2) m_mask = wd[W-1:0];
`ifdef PIO_OUTSETCLR_EN
                if (a == 3'd4) m_data = m_data | wd[W-1:0];
                if (a == 3'd5) m_data = m_data & ~wd[W-1:0];
`endif
            end
            for (int i = S; i > 0; i--) m_hist[i] = m_hist[i-1];
            m_hist[0] = inp;
            m_irq = irq_n;
        end
        @(negedge clk);
    endtask

    task automatic rd(input logic [2:0] a);
        cycle(1'b1, 1'b1, 1'b1, a, 32'h0, tb_in);
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        cycle(1'b1, 1'b1, 1'b0, a, d, tb_in);
    endtask

    task automatic test_reset;
        cycle(1'b0, 1'b0, 1'b1, 3'd0, 32'h0, tb_in);
        cycle(1'b0, 1'b0, 1'b1, 3'd0, 32'h0, tb_in);
        n_vec++; if (out_port !== 8'hA5) begin n_err++; $display("FAIL reset_out_port: got %h want a5", out_port); end
        n_vec++; if (oe !== 8'hFF) begin n_err++; $display("FAIL reset_oe: got %h want ff", oe); end
        n_vec++; if (irq !== 1'b0) begin n_err++; $display("FAIL reset_irq: got %b want 0", irq); end
        rd(3'd2);
        n_vec++; if (readdata !== 32'h0) begin n_err++; $display("FAIL reset_irqmask: got %h want 0", readdata); end
        rd(3'd3);
        n_vec++; if (readdata !== 32'h0) begin n_err++; $display("FAIL reset_edgecap: got %h want 0", readdata); end
    endtask

    task automatic test_data_dir;
        wr(3'd1, 32'h0F);
        wr(3'd0, 32'h3C);
        tb_in = 8'h90;
        repeat (S + 1) rd(3'd0);
        n_vec++; if (readdata !== 32'h9C) begin n_err++; $display("FAIL data_mix: got %h want 0000009c", readdata); end
        n_vec++; if (readdata[31:8] !== 24'h0) begin n_err++; $display("FAIL data_upper: got %h want 0", readdata[31:8]); end
        n_vec++; if (readdata !== m_read(3'd0)) begin n_err++; $display("FAIL data_model: got %h want %h", readdata, m_read(3'd0)); end
    endtask

    task automatic test_edge_irq;
        int  lat;
        bit  found;
        wr(3'd2, 32'h01);
        wr(3'd3, 32'hFF);
        tb_in = 8'h91;
        lat = 0; found = 1'b0;
        repeat (10) begin
            if (!found) begin
                rd(3'd3);
                lat++;
                if (readdata[0] === 1'b1) found = 1'b1;
            end
        end
        n_vec++; if (!found || lat != S + 1) begin n_err++; $display("FAIL edge_latency: got %0d cycles (found=%0d) want %0d", lat, found, S + 1); end
        n_vec++; if (readdata !== 32'h01) begin n_err++; $display("FAIL edgecap_set: got %h want 01", readdata); end
        n_vec++; if (irq !== 1'b0) begin n_err++; $display("FAIL irq_early: got %b want 0", irq); end
        rd(3'd3);
        n_vec++; if (irq !== 1'b1) begin n_err++; $display("FAIL irq_rise: got %b want 1", irq); end
        wr(3'd3, 32'h01);
        n_vec++; if (readdata !== 32'h0) begin n_err++; $display("FAIL edgecap_clear: got %h want 0", readdata); end
        n_vec++; if (irq !== 1'b1) begin n_err++; $display("FAIL irq_hold: got %b want 1", irq); end
        rd(3'd3);
        n_vec++; if (irq !== 1'b0) begin n_err++; $display("FAIL irq_drop: got %b want 0", irq); end
    endtask

    task automatic test_set_wins;
        tb_in = 8'h95;
        repeat (S) rd(3'd3);
        wr(3'd3, 32'h04);
        n_vec++; if (readdata !== 32'h04) begin n_err++; $display("FAIL set_wins: got %h want 04", readdata); end
        n_vec++; if (readdata !== m_read(3'd3)) begin n_err++; $display("FAIL set_wins_model: got %h want %h", readdata, m_read(3'd3)); end
    endtask

    task automatic test_outsetclr;
        logic [W-1:0] exp;
`ifdef PIO_OUTSETCLR_EN
        exp = 8'h3E;
`else
        exp = 8'h0F;
`endif
        wr(3'd0, 32'h0F);
        wr(3'd4, 32'h30);
        wr(3'd5, 32'h01);
        rd(3'd4);
        n_vec++; if (out_port !== exp) begin n_err++; $display("FAIL outsetclr: got %h want %h", out_port, exp); end
        n_vec++; if (readdata !== 32'h0) begin n_err++; $display("FAIL outset_read: got %h want 0", readdata); end
        rd(3'd5);
        n_vec++; if (readdata !== 32'h0) begin n_err++; $display("FAIL outclr_read: got %h want 0", readdata); end
    endtask

    task automatic test_reset_mid;
        wr(3'd2, 32'hFF);
        tb_in = 8'h00;
        repeat (S + 2) rd(3'd3);
        wr(3'd3, 32'hFF);
        tb_in = 8'hFF;
        repeat (S + 3) rd(3'd3);
        n_vec++; if (readdata !== 32'hFF) begin n_err++; $display("FAIL pre_reset_edgecap: got %h want ff", readdata); end
        n_vec++; if (irq !== 1'b1) begin n_err++; $display("FAIL pre_reset_irq: got %b want 1", irq); end
        cycle(1'b0, 1'b1, 1'b1, 3'd3, 32'h0, tb_in);
        n_vec++; if (irq !== 1'b0) begin n_err++; $display("FAIL mid_reset_irq: got %b want 0", irq); end
        n_vec++; if (readdata !== 32'h0) begin n_err++; $display("FAIL mid_reset_edgecap: got %h want 0", readdata); end
        n_vec++; if (out_port !== 8'hA5) begin n_err++; $display("FAIL mid_reset_out_port: got %h want a5", out_port); end
    endtask

    task automatic test_random;
        bit           r, cs, wn;
        logic [2:0]   a;
        logic [31:0]  wd;
        for (int n = 0; n < 400; n++) begin
            r  = ($urandom_range(0, 63) != 0);
            cs = ($urandom_range(0, 3) != 0);
            wn = $urandom_range(0, 1);
            a  = 3'($urandom_range(0, 7));
            wd = $urandom;
            if ($urandom_range(0, 3) == 0) tb_in = 8'($urandom);
            cycle(r, cs, wn, a, wd, tb_in);
            n_vec++; if (out_port !== m_data) begin n_err++; $display("FAIL rnd_out_port[%0d]: got %h want %h", n, out_port, m_data); end
            n_vec++; if (oe !== m_dir) begin n_err++; $display("FAIL rnd_oe[%0d]: got %h want %h", n, oe, m_dir); end
            n_vec++; if (irq !== m_irq) begin n_err++; $display("FAIL rnd_irq[%0d]: got %b want %b", n, irq, m_irq); end
            n_vec++; if (readdata !== m_read(a)) begin n_err++; $display("FAIL rnd_read[%0d] a=%0d: got %h want %h", n, a, readdata, m_read(a)); end
        end
    endtask

    initial begin
        test_reset;
        test_data_dir;
        test_edge_irq;
        test_set_wins;
        test_outsetclr;
        test_reset_mid;
        test_random;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
